// File: rtl/cacheline_burst_adapter.sv
`default_nettype none
// ============================================================================
// Module  : cacheline_burst_adapter
// Brief   : Converts one 256-bit cacheline read/write into a 4x64-bit bmem burst.
// Revision: 1.0
// ============================================================================
module cacheline_burst_adapter #(
  parameter int BEAT_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 dfp_addr,
  input  logic                        dfp_read,
  input  logic                        dfp_write,
  input  logic [BEAT_W*BURST_LEN-1:0] dfp_wdata,
  output logic [BEAT_W*BURST_LEN-1:0] dfp_rdata,
  output logic                        dfp_resp,
  output logic [31:0]                 bmem_addr,
  output logic                        bmem_read,
  output logic                        bmem_write,
  output logic [BEAT_W-1:0]           bmem_wdata,
  input  logic                        bmem_ready,
  input  logic [BEAT_W-1:0]           bmem_rdata,
  input  logic                        bmem_rvalid
);

  localparam int                 c_line_w = BEAT_W * BURST_LEN;
  localparam int                 c_cnt_w  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [c_cnt_w-1:0] c_last   = c_cnt_w'(BURST_LEN - 1);

  localparam logic [2:0] c_idle     = 3'd0;
  localparam logic [2:0] c_rd_issue = 3'd1;
  localparam logic [2:0] c_rd_wait  = 3'd2;
  localparam logic [2:0] c_wr       = 3'd3;
  localparam logic [2:0] c_resp     = 3'd4;

  if (c_line_w != 256) begin : g_line_width_check
    $error("cacheline_burst_adapter: BEAT_W*BURST_LEN must equal 256");
  end

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [31:0]         r_addr;
  logic [c_line_w-1:0] r_buf;
  logic                w_beat_done;
  logic                w_unused_addr_lsbs;

  // Line offset bits never reach the bus; the burst is always line aligned.
  assign w_unused_addr_lsbs = ^dfp_addr[4:0];

  assign w_beat_done = ((r_state == c_rd_wait) && bmem_rvalid) ||
                       ((r_state == c_wr) && bmem_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: begin
        if (dfp_write) begin
          w_state_nxt = c_wr;
        end else if (dfp_read) begin
          w_state_nxt = c_rd_issue;
        end
      end
      c_rd_issue: if (bmem_ready) w_state_nxt = c_rd_wait;
      c_rd_wait:  if (bmem_rvalid && (r_cnt == c_last)) w_state_nxt = c_resp;
      c_wr:       if (bmem_ready && (r_cnt == c_last)) w_state_nxt = c_resp;
      c_resp:     w_state_nxt = c_idle;
      default:    w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    dfp_resp   = 1'b0;
    case (r_state)
      c_rd_issue: bmem_read  = 1'b1;
      c_wr:       bmem_write = 1'b1;
      c_resp:     dfp_resp   = 1'b1;
      default: ;
    endcase
  end

  // Beat counter wraps to zero on the last beat, so it is clean on entry to RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((r_state == c_idle) || (r_state == c_rd_issue)) begin
      r_cnt <= '0;
    end else if (w_beat_done) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
    end
  end

  // Address and line buffer carry no reset: their contents are don't-care until loaded.
  always_ff @(posedge clk) begin
    if (r_state == c_idle) begin
      r_addr <= {dfp_addr[31:5], 5'd0};
      if (dfp_write) begin
        r_buf <= dfp_wdata;
      end
    end else if ((r_state == c_rd_wait) && bmem_rvalid) begin
      r_buf[r_cnt*BEAT_W +: BEAT_W] <= bmem_rdata;
    end
  end

  assign bmem_addr  = r_addr;
  assign bmem_wdata = r_buf[r_cnt*BEAT_W +: BEAT_W];
  assign dfp_rdata  = r_buf;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_burst_adapter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cacheline_burst_adapter
// Brief   : Directed/randomized self-checking bench for cacheline_burst_adapter.
// Revision: 1.0
// ============================================================================
module tb_cacheline_burst_adapter;

  logic         clk;
  logic         rst_n;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int n_tests = 0;
  int n_fail  = 0;
  int n_cycles = 0;
  bit excl_en = 0;

  cacheline_burst_adapter #(.BEAT_W(64), .BURST_LEN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dfp_addr   (dfp_addr),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .dfp_wdata  (dfp_wdata),
    .dfp_rdata  (dfp_rdata),
    .dfp_resp   (dfp_resp),
    .bmem_addr  (bmem_addr),
    .bmem_read  (bmem_read),
    .bmem_write (bmem_write),
    .bmem_wdata (bmem_wdata),
    .bmem_ready (bmem_ready),
    .bmem_rdata (bmem_rdata),
    .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; outputs are observed and inputs driven 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    n_cycles++;
    if (n_cycles > 20000) begin
      $display("FAIL watchdog: observed %0d cycles expected under 20000", n_cycles);
      $fatal(1, "watchdog expired");
    end
    assert (!(dfp_read && dfp_write)) else begin
      n_fail++;
      $error("FAIL req_both_high: observed read=%0b write=%0b expected not both", dfp_read, dfp_write);
    end
    if (excl_en) check("rd_wr_exclusive", {255'd0, bmem_read & bmem_write}, 256'd0);
  endtask

  // Memory model: holds off the read command `stall` cycles, then returns
  // four random beats spaced `gap` idle cycles apart.
  task automatic do_read(input logic [31:0] addr, input int stall, input int gap,
                         input int exp_resp, input string tag);
    logic [63:0]  beats [4];
    logic [255:0] line;
    int cyc, acc, k, n_issue;
    bit done;
    for (int i = 0; i < 4; i++) begin
      beats[i] = {$urandom, $urandom};
      line[i*64 +: 64] = beats[i];
    end
    dfp_addr  = addr;
    dfp_write = 1'b0;
    dfp_read  = 1'b1;
    cyc = 0; acc = -1; k = 0; n_issue = 0; done = 0;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
      bmem_rvalid = 1'b0;
      bmem_rdata  = {$urandom, $urandom};
      if (dfp_resp === 1'b1) begin
        check({tag, "_resp_cycle"}, 256'(cyc), 256'(exp_resp));
        check({tag, "_rdata"}, dfp_rdata, line);
        check({tag, "_issue_cycles"}, 256'(n_issue), 256'(stall + 1));
        bmem_ready = 1'b0;
        done = 1;
      end else begin
        if (acc >= 0 && k < 4 && ((cyc - acc - 1) % (gap + 1)) == 0) begin
          bmem_rvalid = 1'b1;
          bmem_rdata  = beats[k];
          k++;
        end
        if (bmem_read === 1'b1) begin
          n_issue++;
          check({tag, "_addr"}, 256'(bmem_addr), 256'(addr & 32'hFFFF_FFE0));
          if (n_issue <= stall) begin
            bmem_ready = 1'b0;
          end else begin
            bmem_ready = 1'b1;
            acc = cyc;
          end
        end else begin
          bmem_ready = 1'b0;
        end
      end
    end
    if (!done) check({tag, "_timeout"}, 256'(cyc), 256'(exp_resp));
    tick();
    check({tag, "_resp_pulse_end"}, {255'd0, dfp_resp}, 256'd0);
    check({tag, "_no_restart"}, {254'd0, bmem_read, bmem_write}, 256'd0);
    dfp_read = 1'b0;
    tick();
    check({tag, "_idle_after"}, {253'd0, bmem_read, bmem_write, dfp_resp}, 256'd0);
  endtask

  // Memory accepts write beats always (toggle=0) or on alternate cycles starting with 1.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input bit toggle,
                          input int exp_resp, input string tag);
    int cyc, k;
    bit done, ph;
    dfp_addr  = addr;
    dfp_wdata = line;
    dfp_read  = 1'b0;
    dfp_write = 1'b1;
    cyc = 0; k = 0; done = 0; ph = 1;
    while (!done && cyc < 100) begin
      tick();
      cyc++;
      if (dfp_resp === 1'b1) begin
        check({tag, "_resp_cycle"}, 256'(cyc), 256'(exp_resp));
        check({tag, "_beats"}, 256'(k), 256'd4);
        bmem_ready = 1'b0;
        done = 1;
      end else if (bmem_write === 1'b1) begin
        check({tag, "_addr"}, 256'(bmem_addr), 256'(addr & 32'hFFFF_FFE0));
        if (k < 4) begin
          check({tag, "_wdata"}, 256'(bmem_wdata), 256'(line[k*64 +: 64]));
        end else begin
          check({tag, "_extra_beat"}, 256'(k), 256'd3);
        end
        bmem_ready = toggle ? ph : 1'b1;
        ph = ~ph;
        if (bmem_ready) k++;
      end else begin
        bmem_ready = 1'b0;
      end
    end
    if (!done) check({tag, "_timeout"}, 256'(cyc), 256'(exp_resp));
    tick();
    check({tag, "_resp_pulse_end"}, {255'd0, dfp_resp}, 256'd0);
    check({tag, "_no_restart"}, {254'd0, bmem_read, bmem_write}, 256'd0);
    dfp_write = 1'b0;
    tick();
    check({tag, "_idle_after"}, {253'd0, bmem_read, bmem_write, dfp_resp}, 256'd0);
  endtask

  initial begin
    logic [255:0] wline;
    logic [31:0]  raddr;
    int stall, gap;
    bit tog;

    rst_n = 1'b0; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0;
    repeat (3) tick();
    check("reset_outputs", {253'd0, bmem_read, bmem_write, dfp_resp}, 256'd0);
    rst_n = 1'b1;
    excl_en = 1;
    tick();
    check("idle_outputs", {253'd0, bmem_read, bmem_write, dfp_resp}, 256'd0);

    // Fast read: issue cycle 1, beats 2-5, response cycle 6.
    do_read(32'h1234_5678, 0, 0, 6, "rd_fast");
    // Slow read: command held 4 cycles, 2 idle cycles between beats.
    do_read(32'hDEAD_BEEF, 3, 2, 15, "rd_slow");

    // Write, ready always high: beats 1-4, response cycle 5.
    wline = {64'd3, 64'd2, 64'd1, 64'd0};
    do_write(32'hCAFE_F00D, wline, 1'b0, 5, "wr_fast");
    // Write with alternating ready: last beat accepted in cycle 7.
    do_write(32'h0000_1F3F, wline, 1'b1, 8, "wr_bp");

    // Back-to-back write then read.
    wline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_write(32'h8000_0040, wline, 1'b1, 8, "b2b_wr");
    do_read(32'h8000_0040, 0, 0, 6, "b2b_rd");

    // Reset in the middle of a read, then stray beats while idle.
    dfp_addr = 32'h0BAD_0000;
    dfp_read = 1'b1;
    tick();
    check("rst_rd_issue", {255'd0, bmem_read}, 256'd1);
    bmem_ready = 1'b1;
    tick();
    bmem_ready = 1'b0; bmem_rvalid = 1'b1; bmem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
    tick();
    bmem_rdata = 64'hBBBB_BBBB_BBBB_BBBB;
    tick();
    bmem_rvalid = 1'b0; rst_n = 1'b0; dfp_read = 1'b0;
    tick();
    check("rst_mid_outputs", {253'd0, bmem_read, bmem_write, dfp_resp}, 256'd0);
    rst_n = 1'b1;
    tick();
    check("rst_release_resp", {255'd0, dfp_resp}, 256'd0);
    for (int i = 0; i < 2; i++) begin
      bmem_rvalid = 1'b1;
      bmem_rdata  = {$urandom, $urandom};
      tick();
      check("stray_beat_idle", {253'd0, bmem_read, bmem_write, dfp_resp}, 256'd0);
    end
    bmem_rvalid = 1'b0;
    do_read(32'h0BAD_0020, 0, 0, 6, "rd_after_rst");

    // Randomized mix of writes and reads.
    for (int i = 0; i < 4; i++) begin
      wline = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      tog = 1'($urandom_range(0, 1));
      do_write($urandom, wline, tog, tog ? 8 : 5, "rnd_wr");
      stall = $urandom_range(0, 3);
      gap   = $urandom_range(0, 2);
      raddr = $urandom;
      do_read(raddr, stall, gap, 6 + stall + 3 * gap, "rnd_rd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
